// File: rtl/accel_pkg.sv
// Shared definitions for the near-memory CNN accelerator: FSM encodings and
// default bus widths common to the fetch master and the word memory.
package accel_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH    = 32;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding {last, data} between the memory capture stage and
// the downstream valid/ready channel. Entry 0 is always the head.
module fetch_buf #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occupancy,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       count;
  logic             do_pop;
  logic             do_push;
  logic [1:0]       after_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && !((count == 2'd2) && !do_pop);
  assign after_pop = count - 2'(do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      if (do_pop) begin
        slot0 <= slot1;
      end
      // A push lands in the first free slot after this cycle's pop shifts.
      if (do_push) begin
        if (after_pop == 2'd0) begin
          slot0 <= push_data;
        end else begin
          slot1 <= push_data;
        end
      end
      count <= after_pop + 2'(do_push);
    end
  end

  assign occupancy = count;
  assign head      = slot0;

endmodule

// File: rtl/window_fetch.sv
// Read-side bus master: fetches a KxK row-major window from word memory and
// streams it downstream over valid/ready with last on the final element.
module window_fetch
  import accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned K_WIDTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH-1:0] img_width,
  input  logic [K_WIDTH-1:0]       k,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_sel,
  output logic                     mem_w_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int unsigned CNT_WIDTH = 2 * K_WIDTH;

  fetch_state_t state;
  fetch_state_t state_next;

  logic [ADDRESS_WIDTH-1:0] width_q;
  logic [ADDRESS_WIDTH-1:0] row_base;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [K_WIDTH-1:0]       k_q;
  logic [K_WIDTH-1:0]       col;
  logic [CNT_WIDTH-1:0]     elem;
  logic [CNT_WIDTH-1:0]     total;
  logic                     inflight;
  logic                     inflight_last;
  logic [1:0]               occupancy;
  logic [DATA_WIDTH:0]      head;
  logic [2:0]               pending;
  logic                     pop;
  logic                     issue;
  logic                     last_issue;
  logic                     drained;

  assign total      = CNT_WIDTH'(k_q) * CNT_WIDTH'(k_q);
  assign last_issue = (elem == total - CNT_WIDTH'(1));
  assign cur_addr   = row_base + ADDRESS_WIDTH'(col);
  assign pop        = out_valid && out_ready;
  // Slots that will be committed once the read in flight lands, net of this cycle's pop.
  assign pending    = 3'(occupancy) + 3'(inflight) - 3'(pop);
  assign drained    = !inflight && ((occupancy == 2'd0) || ((occupancy == 2'd1) && pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (k != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (issue && last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    issue    = (state == FETCH) && (pending < 3'd2);
    mem_sel  = issue || inflight;
    mem_addr = issue ? cur_addr : addr_q;
    mem_w_en = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q       <= '0;
      row_base      <= '0;
      addr_q        <= '0;
      k_q           <= '0;
      col           <= '0;
      elem          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        width_q  <= img_width;
        k_q      <= k;
        row_base <= base_addr;
        col      <= '0;
        elem     <= '0;
      end
      if (issue) begin
        addr_q <= cur_addr;
        elem   <= elem + CNT_WIDTH'(1);
        if (col == k_q - K_WIDTH'(1)) begin
          col      <= '0;
          row_base <= row_base + width_q;
        end else begin
          col <= col + K_WIDTH'(1);
        end
      end
      inflight      <= issue;
      inflight_last <= issue && last_issue;
    end
  end

  fetch_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, mem_data}),
    .pop       (pop),
    .occupancy (occupancy),
    .head      (head)
  );

  assign out_valid = (occupancy != 2'd0);
  assign out_data  = head[DATA_WIDTH-1:0];
  assign out_last  = out_valid && head[DATA_WIDTH];

endmodule

// File: tb/tb_window_fetch.sv
// Self-checking bench for window_fetch: table of directed windows, hand-written
// latency/stall/reset/ignored-start sequences, and randomized windows vs a model.
module tb_window_fetch;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] img_width;
  logic [KW-1:0] k;
  logic          busy;
  logic          done;
  logic          mem_sel;
  logic          mem_w_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  window_fetch #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .K_WIDTH      (KW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .img_width(img_width),
    .k        (k),
    .busy     (busy),
    .done     (done),
    .mem_sel  (mem_sel),
    .mem_w_en (mem_w_en),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  // Word memory: registered read, data visible only while select stays high.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_q;
  always @(posedge clk) if (mem_sel && !mem_w_en) rd_q <= mem[mem_addr];
  assign mem_data = mem_sel ? rd_q : 32'hBAD0_BAD0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_exp = -1;
  bit done_seen = 1'b0;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted word matches the queue head; done follows the last pop.
  always @(negedge clk) begin
    if (!rst) begin
      check("mem_w_en", {31'b0, mem_w_en}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected no word (cycle %0d)", out_data, cyc);
        end else begin
          check("out_data", out_data, exp_q[0]);
          check("out_last", {31'b0, out_last}, {31'b0, exp_q.size() == 1});
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_exp = cyc + 1;
        end
      end
      if (cyc == done_exp) begin
        check("done", {31'b0, done}, 32'd1);
        done_seen = 1'b1;
        done_exp = -1;
      end else if (done) begin
        check("done_spurious", {31'b0, done}, 32'd0);
      end
    end
  end

  typedef struct {
    logic [7:0]      base;
    logic [7:0]      width;
    logic [3:0]      kk;
    int              n;
    logic [0:8][7:0] words;
  } vec_t;

  vec_t vecs[6];

  task automatic mem_identity();
    for (int a = 0; a < 256; a++) mem[a] = DW'(a);
  endtask

  task automatic load_vec(input int i);
    exp_q.delete();
    for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(DW'(vecs[i].words[j]));
  endtask

  task automatic launch(input logic [7:0] b, input logic [7:0] w, input logic [3:0] kk);
    done_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; img_width = w; k = kk;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 8'($urandom); img_width = 8'($urandom); k = 4'($urandom);
    if (kk == 4'd0) done_exp = cyc;
  endtask

  task automatic finish_window(input bit rnd, output int busy_cycles, output int sel_cycles);
    busy_cycles = 0;
    sel_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if (rnd) out_ready = ($urandom_range(3) != 0);
      #1;
      if (busy) busy_cycles++;
      if (mem_sel) sel_cycles++;
      if (done_seen && exp_q.size() == 0 && !busy) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL timeout: got %0d words pending expected 0 with done", exp_q.size());
  endtask

  task automatic wait_pending(input int target);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == target) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL wait_words: got %0d pending expected %0d", exp_q.size(), target);
  endtask

  initial begin
    int bc;
    int sc;
    vecs[0] = '{8'h10, 8'h08, 4'd3, 9, {8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A, 8'h20, 8'h21, 8'h22}};
    vecs[1] = '{8'hFE, 8'h04, 4'd2, 4, {8'hFE, 8'hFF, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{8'h40, 8'h00, 4'd2, 4, {8'h40, 8'h41, 8'h40, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{8'h05, 8'h01, 4'd1, 1, {8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{8'h33, 8'h05, 4'd0, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[5] = '{8'hF0, 8'h10, 4'd3, 9, {8'hF0, 8'hF1, 8'hF2, 8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12}};

    rst = 1'b1; start = 1'b0; base_addr = '0; img_width = '0; k = '0; out_ready = 1'b1;
    mem_identity();
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_mem_sel", {31'b0, mem_sel}, 0);
    check("rst_mem_addr", {24'b0, mem_addr}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", {31'b0, out_last}, 0);
    rst = 1'b0;

    // Directed table: busy spans issue cycle 1 through done at cycle n+3 (1 cycle for k=0).
    for (int i = 0; i < 6; i++) begin
      mem_identity();
      load_vec(i);
      launch(vecs[i].base, vecs[i].width, vecs[i].kk);
      finish_window(1'b0, bc, sc);
      check($sformatf("busy_cycles_v%0d", i), bc, (vecs[i].n == 0) ? 1 : vecs[i].n + 3);
      if (vecs[i].n == 0) check("k0_mem_sel", sc, 0);
    end

    // First-word latency.
    load_vec(0);
    launch(8'h10, 8'h08, 4'd3);
    #1;
    check("lat_c1_mem_sel", {31'b0, mem_sel}, 1);
    check("lat_c1_mem_addr", {24'b0, mem_addr}, 32'h10);
    @(posedge clk); #2;
    check("lat_c2_out_valid", {31'b0, out_valid}, 0);
    @(posedge clk); #2;
    check("lat_c3_out_valid", {31'b0, out_valid}, 1);
    check("lat_c3_out_data", out_data, 32'h10);
    finish_window(1'b0, bc, sc);

    // Downstream stall after the 2nd word: buffer fills, then the bus goes quiet.
    load_vec(0);
    launch(8'h10, 8'h08, 4'd3);
    wait_pending(7);
    out_ready = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      if (s >= 3) begin
        check("stall_mem_sel", {31'b0, mem_sel}, 0);
        check("stall_out_valid", {31'b0, out_valid}, 1);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    finish_window(1'b0, bc, sc);

    // Asynchronous reset after the 4th word, then a fresh window.
    load_vec(0);
    launch(8'h10, 8'h08, 4'd3);
    wait_pending(5);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_done", {31'b0, done}, 0);
    check("mid_rst_mem_sel", {31'b0, mem_sel}, 0);
    check("mid_rst_mem_addr", {24'b0, mem_addr}, 0);
    check("mid_rst_out_valid", {31'b0, out_valid}, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_last", {31'b0, out_last}, 0);
    exp_q.delete();
    done_exp = -1;
    @(posedge clk); #1;
    rst = 1'b0;
    load_vec(0);
    launch(8'h10, 8'h08, 4'd3);
    finish_window(1'b0, bc, sc);
    check("post_rst_busy_cycles", bc, 12);

    // Start pulse with other inputs while busy must be ignored.
    load_vec(0);
    launch(8'h10, 8'h08, 4'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h80; img_width = 8'h01; k = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    finish_window(1'b0, bc, sc);
    repeat (6) @(posedge clk);
    #1;
    check("ignored_start_busy", {31'b0, busy}, 0);

    // Randomized windows against the row-major address model.
    for (int t = 0; t < 30; t++) begin
      logic [7:0] b;
      logic [7:0] w;
      logic [3:0] kk;
      for (int a = 0; a < 256; a++) mem[a] = $urandom;
      b = 8'($urandom);
      w = (t % 5 == 0) ? 8'd0 : 8'($urandom);
      kk = (t == 7) ? 4'd15 : 4'($urandom_range(0, 6));
      exp_q.delete();
      for (int r = 0; r < int'(kk); r++)
        for (int c = 0; c < int'(kk); c++)
          exp_q.push_back(mem[8'(int'(b) + r * int'(w) + c)]);
      launch(b, w, kk);
      finish_window(1'b1, bc, sc);
    end
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
